// File: rtl/wrm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wrm_pkg
// Brief    : Shared state encoding and default sizing for the FIFO write manager.
// Revision : 1.0
// ============================================================================
package wrm_pkg;

    typedef enum logic [0:0] {
        PASS = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int c_SKID_DEPTH = 4;
    localparam int c_CNT_W      = 16;

endpackage : wrm_pkg
`default_nettype wire

// File: rtl/wrm_skid.sv
`default_nettype none
// ============================================================================
// Module   : wrm_skid
// Brief    : Circular skid buffer; a push into a full buffer is taken only alongside a pop.
// Revision : 1.0
// ============================================================================
module wrm_skid
    import wrm_pkg::*;
#(
    parameter int DEPTH = c_SKID_DEPTH,
    parameter int W     = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             iv_din,
    output logic [W-1:0]             ov_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   ov_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_cnt;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign ov_head   = r_mem[r_rd_ptr];
    assign ov_count  = r_cnt;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= iv_din;
        end
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule : wrm_skid
`default_nettype wire

// File: rtl/wrm.sv
`default_nettype none
// ============================================================================
// Module   : wrm
// Brief    : Write-side manager of a byte FIFO with an in-order skid buffer.
// Revision : 1.0
// ============================================================================
module wrm
    import wrm_pkg::*;
#(
    parameter int SKID_DEPTH = c_SKID_DEPTH,
    parameter int CNT_W      = c_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       iv_data,
    input  logic             i_data_wr,
    input  logic             i_fifo_full,
    input  logic             i_fifo_af,
    output logic [7:0]       ov_fifo_data,
    output logic             o_fifo_wr,
    output logic             o_busy,
    output logic             o_overflow,
    output logic [CNT_W-1:0] ov_drop_cnt
);

    localparam int AW = $clog2(SKID_DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic             w_stall;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_load;
    logic [7:0]       w_load_data;
    logic [7:0]       w_head;
    logic             w_skid_empty;
    logic             w_skid_full;
    logic [AW:0]      w_count;
    logic [7:0]       r_fifo_data;
    logic             r_fifo_wr;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_stall = i_fifo_af | i_fifo_full;

    wrm_skid #(
        .DEPTH (SKID_DEPTH),
        .W     (8)
    ) u_skid (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .iv_din   (iv_data),
        .ov_head  (w_head),
        .o_empty  (w_skid_empty),
        .o_full   (w_skid_full),
        .ov_count (w_count)
    );

    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_drop      = 1'b0;
        w_load      = 1'b0;
        w_load_data = iv_data;
        case (r_state)
            PASS: begin
                if (i_data_wr) begin
                    if (w_stall) begin
                        w_push = 1'b1;
                        w_next = HOLD;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                // New bytes always queue behind the skid contents to keep order.
                w_pop = ~w_stall & ~w_skid_empty;
                if (i_data_wr) begin
                    if (~w_skid_full | w_pop) begin
                        w_push = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                if (w_pop) begin
                    w_load      = 1'b1;
                    w_load_data = w_head;
                    if ((w_count == (AW+1)'(1)) && !w_push) begin
                        w_next = PASS;
                    end
                end
            end
            default: w_next = PASS;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= PASS;
            r_fifo_wr   <= 1'b0;
            r_fifo_data <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state   <= w_next;
            r_fifo_wr <= w_load;
            if (w_load) begin
                r_fifo_data <= w_load_data;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign ov_fifo_data = r_fifo_data;
    assign o_fifo_wr    = r_fifo_wr;
    assign o_busy       = (r_state == HOLD);
    assign o_overflow   = r_overflow;
    assign ov_drop_cnt  = r_drop_cnt;

endmodule : wrm
`default_nettype wire

// File: doc/wrm.md
WRM -- requirements
Module: wrm

Interface
REQ-001 SKID_DEPTH, default 4, skid buffer depth in bytes; SHALL be a power of two, at least 2.
REQ-002 CNT_W, default 16, width of the drop counter.
REQ-003 i_clk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 iv_data  input  8  upstream byte.
REQ-006 i_data_wr  input  1  upstream byte strobe; no backpressure to upstream exists.
REQ-007 i_fifo_full  input  1  downstream show-ahead FIFO full flag.
REQ-008 i_fifo_af  input  1  downstream FIFO almost-full flag; the system SHALL set the threshold at or below depth-2.
REQ-009 ov_fifo_data  output  8  FIFO write data, registered.
REQ-010 o_fifo_wr  output  1  FIFO write strobe, registered.
REQ-011 o_busy  output  1  high while the state is HOLD.
REQ-012 o_overflow  output  1  sticky flag indicating at least one byte was dropped.
REQ-013 ov_drop_cnt  output  CNT_W  count of dropped bytes, saturating.

Function
REQ-014 Block SHALL be the write-side manager of a byte FIFO: upstream bytes in, FIFO writes out, byte order strictly preserved.
REQ-015 Throttle term "stall" SHALL equal i_fifo_af OR i_fifo_full, sampled in the same cycle the write decision is made.
REQ-016 States SHALL be PASS (skid empty) and HOLD (skid non-empty).
REQ-017 PASS, i_data_wr=1, stall=0: byte SHALL appear on ov_fifo_data with o_fifo_wr=1 exactly one cycle later.
REQ-018 PASS, i_data_wr=1, stall=1: byte SHALL be pushed to skid; next state HOLD; o_fifo_wr=0 next cycle.
REQ-019 PASS, i_data_wr=0: o_fifo_wr SHALL be 0 next cycle; state remains PASS.
REQ-020 HOLD, stall=0: skid head SHALL be popped and written to FIFO the next cycle (one byte per cycle max).
REQ-021 HOLD, i_data_wr=1: byte SHALL be pushed to skid tail, never bypassing it; push and pop SHALL be allowed in the same cycle.
REQ-022 HOLD to PASS SHALL occur when a pop empties the skid and no push occurs in that cycle.
REQ-023 Skid full, i_data_wr=1, no pop in that cycle: byte SHALL be dropped, skid contents unchanged, ov_drop_cnt incremented.
REQ-024 Skid full with simultaneous pop and push: push SHALL be accepted; no drop.
REQ-025 ov_drop_cnt SHALL saturate at all-ones and never wrap.
REQ-026 o_overflow SHALL set in the cycle after the first drop and remain set until reset.
REQ-027 o_fifo_wr SHALL never be 1 in a cycle following one where stall=1.
REQ-028 Skid pointers SHALL wrap modulo SKID_DEPTH; occupancy counter SHALL be log2(SKID_DEPTH)+1 bits.

Reset
REQ-029 With i_rst=1 at a clock edge: state PASS, skid empty, o_fifo_wr=0, ov_fifo_data=0, o_busy=0, o_overflow=0, ov_drop_cnt=0.
REQ-030 Reset mid-operation SHALL discard skid contents; i_data_wr during reset SHALL be ignored and not counted as a drop.
REQ-031 The first byte accepted after i_rst falls SHALL follow REQ-017 timing.

Structure
REQ-032 Package wrm_pkg SHALL hold the state enum (PASS, HOLD) and default constants SKID_DEPTH and CNT_W.
REQ-033 Skid storage SHALL be one sub-module, wrm_skid: circular buffer with push, pop, head data, empty, full, and occupancy outputs.
REQ-034 wrm SHALL contain the FSM, output registers, and drop counter; no vendor primitives.

Verification
REQ-035 Stream 0x01..0x10 on consecutive cycles, stall=0 -> 16 writes, each one cycle later, same order, o_busy=0 throughout.
REQ-036 Assert af for 3 cycles while 0xA0..0xA2 arrive, then deassert -> o_busy=1, then writes A0,A1,A2 on consecutive cycles, then return to PASS.
REQ-037 Hold af with SKID_DEPTH=4 and 6 bytes 0x10..0x15 -> 0x10..0x13 retained, ov_drop_cnt=2, o_overflow=1; after release, writes 10..13 only.
REQ-038 Skid full, release af while bytes keep arriving every cycle -> no further drops; continuous writes with order intact.
REQ-039 CNT_W=4 and 20 forced drops -> ov_drop_cnt stays at 0xF.
REQ-040 Pulse i_rst in HOLD with 3 bytes in the skid -> all outputs at reset values, no residual writes, next byte passes with 1-cycle latency.
